// File: rtl/orion_kbd_pkg.sv
// Shared types and constants for the Orion-PRO keyboard responder.
package orion_kbd_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} kbd_state_t;

  localparam logic [7:0] KBD_RELEASE_ALL = 8'hFF;
  localparam int         KBD_BIT_RELEASE = 7;
  localparam int         KBD_BIT_MOD     = 6;

  localparam logic [1:0] MOD_SHIFT = 2'd0;
  localparam logic [1:0] MOD_CTRL  = 2'd1;
  localparam logic [1:0] MOD_RUS   = 2'd2;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/orion_kbd_matrix_if.sv
// Host key-event stream: valid/ready handshake carrying one 8-bit event code.
interface orion_kbd_matrix_if;
  logic       i_key_valid;
  logic       o_key_ready;
  logic [7:0] i_key_code;

  modport master (output i_key_valid, output i_key_code, input o_key_ready);
  modport slave  (input i_key_valid, input i_key_code, output o_key_ready);
endinterface

// File: rtl/orion_kbd_fifo.sv
// Synchronous first-word-fall-through FIFO; extra pointer MSB separates full from empty.
module orion_kbd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/orion_kbd_matrix.sv
// Keyboard responder: buffers host key events, applies them to an 8x8 matrix plus
// modifiers with a minimum hold between events, and answers row scans with column data.
//   state | meaning
//   IDLE  | waiting; pops the next event when the FIFO holds one
//   APPLY | updates matrix/modifiers from the popped code, loads hold counter
//   HOLD  | counts down so the CPU scan loop sees the change
module orion_kbd_matrix
  import orion_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 20000
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  orion_kbd_matrix_if.slave        key_if,
  input  logic [7:0]               i_row_sel_n,
  output logic [7:0]               o_col_n,
  output logic [2:0]               o_mod_n,
  output logic                     o_busy
);
  localparam int            CW        = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  kbd_state_t      r_state;
  kbd_state_t      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_code;
  logic [7:0][7:0] r_key;
  logic [2:0]      r_mod;
  logic [7:0]      w_col;
  logic [7:0]      w_fifo_data;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_busy_nxt;

  assign key_if.o_key_ready = ~w_full;
  assign w_push             = key_if.i_key_valid & ~w_full;

  orion_kbd_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_data    (key_if.i_key_code),
    .i_pop     (w_pop),
    .o_data    (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = APPLY;
        end
      end
      APPLY:   w_state_nxt = HOLD;
      HOLD:    if (r_cnt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt  <= '0;
      r_code <= '0;
      r_key  <= '0;
      r_mod  <= '0;
    end else begin
      if (w_pop) r_code <= w_fifo_data;
      if (r_state == APPLY) begin
        r_cnt <= HOLD_LOAD;
        if (r_code == KBD_RELEASE_ALL) begin
          r_key <= '0;
          r_mod <= '0;
        end else if (r_code[KBD_BIT_MOD]) begin
          // modifier indices above RUS are accepted but change nothing
          if (r_code[2:0] <= {1'b0, MOD_RUS})
            r_mod[r_code[1:0]] <= ~r_code[KBD_BIT_RELEASE];
        end else begin
          r_key[r_code[5:3]][r_code[2:0]] <= ~r_code[KBD_BIT_RELEASE];
        end
      end else if (r_state == HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_comb begin
    w_col = '0;
    for (int r = 0; r < 8; r++) begin
      if (!i_row_sel_n[r]) w_col = w_col | r_key[r];
    end
  end

  // a pop always moves the FSM out of IDLE, so pending-FIFO or non-IDLE covers busy
  assign w_busy_nxt = w_push | ~w_empty | (w_state_nxt != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_col_n <= 8'hFF;
      o_mod_n <= 3'b111;
      o_busy  <= 1'b0;
    end else begin
      o_col_n <= ~w_col;
      o_mod_n <= ~r_mod;
      o_busy  <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_orion_kbd_matrix.sv
// Scoreboard bench for orion_kbd_matrix: expected output changes are queued with the cycle they must appear on.
module tb_orion_kbd_matrix;
  localparam int HOLD  = 50;
  localparam int DEPTH = 8;
  localparam int SPACE = HOLD + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] row_sel_n = 8'h00;
  logic [7:0] col_n;
  logic [2:0] mod_n;
  logic       busy;

  orion_kbd_matrix_if kif ();

  orion_kbd_matrix #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .key_if      (kif),
    .i_row_sel_n (row_sel_n),
    .o_col_n     (col_n),
    .o_mod_n     (mod_n),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] col;
    logic [2:0] mod;
    int         at;
  } exp_t;
  exp_t sb[$];

  bit         mon_en = 1'b0;
  logic [10:0] last_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_out(input logic [7:0] c, input logic [2:0] m, input int at);
    exp_t e;
    e.col = c;
    e.mod = m;
    e.at  = at;
    sb.push_back(e);
  endfunction

  // monitor: every visible change of col/mod must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && ({col_n, mod_n} !== last_seen)) begin
      last_seen = {col_n, mod_n};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: got col_n %h mod_n %b, required no change (cycle %0d)",
                 col_n, mod_n, cyc);
      end else begin
        e = sb.pop_front();
        check("col_n", col_n, e.col);
        check("mod_n", mod_n, e.mod);
        check("change_cycle", cyc, e.at);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input logic [7:0] code, output int edge_n);
    int guard;
    guard = 0;
    kif.i_key_valid = 1'b1;
    kif.i_key_code  = code;
    @(negedge clk);
    while (!kif.o_key_ready && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 500) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ready stayed %b, required 1", kif.o_key_ready);
    end
    step();
    edge_n = cyc;
    kif.i_key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy %b, required 0", busy);
    end
    step();
  endtask

  logic [7:0] bp_code [12];
  logic [7:0] bp_col  [12];

  initial begin
    int n, n0, x;
    bp_code = '{8'h00, 8'h09, 8'h12, 8'h1B, 8'h24, 8'h2D,
                8'h80, 8'h89, 8'h92, 8'h9B, 8'hA4, 8'hAD};
    bp_col  = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0,
                8'hC1, 8'hC3, 8'hC7, 8'hCF, 8'hDF, 8'hFF};
    kif.i_key_valid = 1'b0;
    kif.i_key_code  = 8'h00;

    // reset defaults, all rows selected
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_col_n", col_n, 8'hFF);
    check("rst_mod_n", mod_n, 3'b111);
    check("rst_ready", kif.o_key_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    last_seen = {col_n, mod_n};
    mon_en = 1'b1;
    step();

    // press row3 col2, scan row3 then row2
    row_sel_n = 8'hF7;
    push(8'h1A, n);
    expect_out(8'hFB, 3'b111, n + 3);
    wait_until(n + 1);
    @(negedge clk);
    check("busy_after_push", busy, 1'b1);
    wait_until(n + HOLD + 1);
    @(negedge clk);
    check("busy_last_hold", busy, 1'b1);
    wait_until(n + HOLD + 2);
    @(negedge clk);
    check("busy_fall", busy, 1'b0);
    step();
    row_sel_n = 8'hFB;
    expect_out(8'hFF, 3'b111, cyc + 1);
    step(); step();
    row_sel_n = 8'hF7;
    expect_out(8'hFB, 3'b111, cyc + 1);
    step(); step();
    push(8'h9A, n);
    expect_out(8'hFF, 3'b111, n + 3);
    wait_idle();

    // multi-row OR over rows 0 and 7
    row_sel_n = 8'h7E;
    step(); step();
    push(8'h00, n);
    expect_out(8'hFE, 3'b111, n + 3);
    wait_idle();
    push(8'h3F, n);
    expect_out(8'h7E, 3'b111, n + 3);
    wait_idle();

    // modifiers, an ignored modifier index that still holds, then release-all
    push(8'h40, n);
    expect_out(8'h7E, 3'b110, n + 3);
    wait_idle();
    push(8'h42, n);
    expect_out(8'h7E, 3'b010, n + 3);
    wait_idle();
    push(8'h45, n);
    push(8'hFF, x);
    expect_out(8'hFF, 3'b111, n + 3 + SPACE);
    wait_idle();
    row_sel_n = 8'h00;
    step(); step();

    // backpressure: 12 back-to-back events into an 8-deep FIFO
    n0 = 0;
    for (int k = 0; k < 12; k++) begin
      push(bp_code[k], n);
      if (k == 0) begin
        n0 = n;
        for (int j = 0; j < 12; j++) expect_out(bp_col[j], 3'b111, n0 + 3 + SPACE * j);
      end
      if (k == 8) check("ready_when_full", kif.o_key_ready, 1'b0);
      if (k == 9) check("stalled_push_cycle", n, n0 + SPACE + 2);
    end
    wait_idle();

    // reset during HOLD with three events still queued
    push(8'h3F, n);
    expect_out(8'h7F, 3'b111, n + 3);
    push(8'h00, x);
    push(8'h09, x);
    push(8'h40, x);
    wait_until(n + 20);
    reset_n = 1'b0;
    expect_out(8'hFF, 3'b111, cyc + 1);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("busy_after_reset", busy, 1'b0);
    check("ready_after_reset", kif.o_key_ready, 1'b1);
    step();
    repeat (200) step();
    @(negedge clk);
    check("busy_quiet", busy, 1'b0);
    check("col_quiet", col_n, 8'hFF);
    check("mod_quiet", mod_n, 3'b111);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
